// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  localparam logic [5:0] OPC_J = 6'b000010;

  localparam int unsigned DEF_AW  = 5;
  localparam int unsigned ENTRY_W = DEF_AW + 32;

  function automatic int unsigned entry_w(input int unsigned aw);
    return aw + 32;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with flush, concurrent push/pop and occupancy count.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [W-1:0]                 i_din,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PW'(1);
      if (w_do_pop)  r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC, ROM addressing, prefetch buffer, redirect and self-jump halt.
// Optional IFETCH_PERF_EN adds saturating push / stall counters (perf_fetch, perf_stall).
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned    DEPTH    = 2,
  parameter int unsigned    AW       = 5,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_data,
  output logic [AW-1:0] inst_pc,
  output logic          halted,
  output logic          busy
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch,
  output logic [15:0]   perf_stall
`endif
);

  localparam int unsigned EW = entry_w(AW);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_hold_data;
  logic [AW-1:0] r_hold_pc;

  logic [EW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic          w_valid;
  logic          w_flush;
  logic          w_pop;
  logic          w_space;
  logic          w_push;
  logic          w_selfjump;

  assign w_valid    = (w_count != '0);
  assign w_flush    = redirect_valid && (r_state != ST_IDLE);
  assign w_pop      = w_valid && inst_ready && !w_flush;
  assign w_space    = (w_count != FULL) || w_pop;
  assign w_push     = (r_state == ST_RUN) && !redirect_valid && w_space;
  assign w_selfjump = (rom_data[31:26] == OPC_J) && (rom_data[25:0] == 26'(r_pc));

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   ({r_pc, rom_data}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (redirect_valid) begin
            r_pc <= redirect_addr;
          end else if (w_push) begin
            // The self-jump word is still delivered; the PC parks on it.
            if (w_selfjump) r_state <= ST_HALT;
            else            r_pc    <= r_pc + AW'(1);
          end
        end
        ST_HALT: begin
          if (redirect_valid) begin
            r_state <= ST_RUN;
            r_pc    <= redirect_addr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Keeps the last presented head visible once the buffer empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_hold_pc   <= '0;
    end else if (w_valid) begin
      r_hold_data <= w_head[31:0];
      r_hold_pc   <= w_head[EW-1:32];
    end
  end

  assign rom_addr   = r_pc;
  assign inst_valid = w_valid;
  assign inst_data  = w_valid ? w_head[31:0]    : r_hold_data;
  assign inst_pc    = w_valid ? w_head[EW-1:32] : r_hold_pc;
  assign halted     = (r_state == ST_HALT);
  assign busy       = (r_state == ST_RUN);

`ifdef IFETCH_PERF_EN
  logic [15:0] r_perf_fetch;
  logic [15:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (r_state == ST_RUN) && (w_count == FULL) && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push  && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 16'd1;
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected {pc, word} pushed per scenario, popped on each accepted transfer.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [4:0]  inst_pc;
  logic        halted;
  logic        busy;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch;
  logic [15:0] perf_stall;
`endif

  logic [31:0] rom [32];
  logic [36:0] sb [$];
  int unsigned n_vec;
  int unsigned n_err;

  ifetch_ctrl #(
    .DEPTH    (2),
    .AW       (5),
    .RESET_PC (5'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .halted         (halted),
    .busy           (busy)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch     (perf_fetch),
    .perf_stall     (perf_stall)
`endif
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned a, input int unsigned b);
    for (int unsigned i = a; i <= b; i++) sb.push_back({i[4:0], rom[i]});
  endtask

  task automatic wait_halt(input int unsigned lim);
    int unsigned n;
    n = 0;
    while (!(halted && !inst_valid) && (n < lim)) begin
      @(negedge clk);
      n++;
    end
    chk("halt_timeout", 64'(n >= lim), 0);
    chk("sb_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", sb.size(), 1);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("acc_pc", inst_pc, e[36:32]);
        chk("acc_data", inst_data, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int unsigned i = 0; i < 32; i++) rom[i] = 32'h2400_0000 + (i * 32'h0001_0101);
    rom[0]  = 32'h0000_0800;
    rom[1]  = 32'h2402_000B;
    rom[11] = 32'h0800_000B;
    rom[31] = 32'h0000_0000;

    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_busy", busy, 0);

    // Redirect must not leave IDLE.
    tick(); redirect_valid = 1'b1; redirect_addr = 5'd5;
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("idle_redir_busy", busy, 0);
    chk("idle_redir_addr", rom_addr, 0);
    chk("idle_redir_valid", inst_valid, 0);

    // Free-running fetch to the self-jump at 11.
    tick(); inst_ready = 1'b1; push_exp(0, 11); start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_addr", rom_addr, 0);
    chk("start_valid", inst_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_valid", inst_valid, 1);
    chk("lat_data", inst_data, 32'h0000_0800);
    chk("lat_pc", inst_pc, 0);
    repeat (12) @(negedge clk);
    chk("run_sb_empty", sb.size(), 0);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_addr", rom_addr, 11);
    chk("halt_hold_pc", inst_pc, 11);
    chk("halt_hold_data", inst_data, 32'h0800_000B);
    repeat (3) @(negedge clk);
    chk("halt_stay_addr", rom_addr, 11);
    chk("halt_stay_valid", inst_valid, 0);

    tick(); push_exp(0, 11); redirect_valid = 1'b1; redirect_addr = 5'd0;
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("unhalt_busy", busy, 1);
    chk("unhalt_halted", halted, 0);
    wait_halt(60);

    // Backpressure from start.
    tick(); rst_n = 1'b0;
    #2 rst_n = 1'b1;
    sb.delete();
    tick(); inst_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_addr1", rom_addr, 1);
    tick();
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("bp_addr_hold", rom_addr, 2);
    end
    chk("bp_valid", inst_valid, 1);
    chk("bp_head_pc", inst_pc, 0);
`ifdef IFETCH_PERF_EN
    chk("perf_stall", perf_stall, 3);
    chk("perf_fetch", perf_fetch, 2);
`endif
    tick(); push_exp(0, 11); inst_ready = 1'b1;
    wait_halt(60);
`ifdef IFETCH_PERF_EN
    chk("perf_fetch_end", perf_fetch, 12);
`endif

    // Flush of a full buffer holding 8,9; refetch from 3.
    tick(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 5'd8;
    tick(); redirect_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("fl_pre_valid", inst_valid, 1);
    chk("fl_pre_pc", inst_pc, 8);
    chk("fl_pre_addr", rom_addr, 10);
    tick(); redirect_valid = 1'b1; redirect_addr = 5'd3;
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("fl_valid", inst_valid, 0);
    chk("fl_addr", rom_addr, 3);
    chk("fl_hold_pc", inst_pc, 8);
    tick(); push_exp(3, 11); inst_ready = 1'b1;
    wait_halt(60);

    // PC wrap 30,31,0,1,...
    tick(); push_exp(30, 31); push_exp(0, 11); redirect_valid = 1'b1; redirect_addr = 5'd30;
    tick(); redirect_valid = 1'b0;
    wait_halt(80);

    // Asynchronous reset with two entries buffered.
    tick(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 5'd0;
    tick(); redirect_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("ar_pre_valid", inst_valid, 1);
    chk("ar_pre_addr", rom_addr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", inst_valid, 0);
    chk("ar_addr", rom_addr, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pc", inst_pc, 0);
    chk("ar_data", inst_data, 0);
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_valid", inst_valid, 0);
    sb.delete();
    tick(); push_exp(0, 11); inst_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_halt(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
